// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared definitions for the RISC-V pipeline stages:
//   - branch funct3 encodings (BR_*)
//   - ex_mem_t : EX/MEM pipeline register bundle
//   - EX_MEM_BUBBLE : all-zero bundle (also the reset value)
//   - make_bubble() : clears control bits of a bundle while keeping its data
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

    localparam int XLEN_C = 32;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef struct packed {
        logic              valid;
        logic [XLEN_C-1:0] pc;
        logic [XLEN_C-1:0] wb_data;
        logic [XLEN_C-1:0] store_data;
        logic              mem_rd;
        logic              mem_wr;
        logic [2:0]        mem_size;
        logic [4:0]        rd;
        logic              rd_wr;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '0;

    // A bubble only kills the control bits; data fields are left as they were
    // so that a squashed slot does not toggle the wide datapath registers.
    function automatic ex_mem_t make_bubble(input ex_mem_t prev);
        ex_mem_t b;
        b        = prev;
        b.valid  = EX_MEM_BUBBLE.valid;
        b.mem_rd = EX_MEM_BUBBLE.mem_rd;
        b.mem_wr = EX_MEM_BUBBLE.mem_wr;
        b.rd_wr  = EX_MEM_BUBBLE.rd_wr;
        return b;
    endfunction

endpackage

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
// Combinational branch/jump resolution for the EX stage.
// Ports:
//   valid_ex_i              EX slot holds a real instruction
//   res_alu_i, z_alu_i, n_alu_i  ALU result and flags
//   br_en_i, br_type_i      conditional branch and its funct3
//   jal_i, jalr_i           unconditional jumps
//   br_target_i             precomputed PC+imm
//   taken_o                 control transfer is taken
//   target_o                resolved target address
//   misalign_o              taken and target not 4-byte aligned
// -----------------------------------------------------------------------------
module branch_unit
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            valid_ex_i,
    input  logic [XLEN-1:0] res_alu_i,
    input  logic            z_alu_i,
    input  logic            n_alu_i,
    input  logic            br_en_i,
    input  logic [2:0]      br_type_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

    logic w_cond;
    logic w_lt_u;

    // For unsigned branches decode routes SLTU through the ALU, so bit 0 of
    // the result is the less-than answer.
    assign w_lt_u = res_alu_i[0];

    always_comb begin
        w_cond = 1'b0;
        case (br_type_i)
            BR_BEQ:  w_cond = z_alu_i;
            BR_BNE:  w_cond = ~z_alu_i;
            BR_BLT:  w_cond = n_alu_i;
            BR_BGE:  w_cond = ~n_alu_i;
            BR_BLTU: w_cond = w_lt_u;
            BR_BGEU: w_cond = ~w_lt_u;
            default: w_cond = 1'b0;  // 010/011 are not branches
        endcase
    end

    assign taken_o    = valid_ex_i & (jal_i | jalr_i | (br_en_i & w_cond));
    assign target_o   = jalr_i ? {res_alu_i[XLEN-1:1], 1'b0} : br_target_i;
    assign misalign_o = taken_o & (target_o[1:0] != 2'b00);

endmodule

// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
// EX->MEM pipeline register with branch resolution and front-end redirect.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   *_ex_i / *_i            EX-stage instruction, ALU result/flags, control
//   stall_i, flush_i        hold / squash the EX/MEM register (flush wins)
//   *_mem_o                 registered EX/MEM fields for the memory stage
//   redirect_o/redirect_pc_o  one-cycle registered fetch redirect
//   misalign_exc_o          one-cycle registered misaligned-target exception
// -----------------------------------------------------------------------------
module ex_mem_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_ex_i,
    input  logic [XLEN-1:0] pc_ex_i,
    input  logic [XLEN-1:0] res_alu_i,
    input  logic            z_alu_i,
    input  logic            n_alu_i,
    input  logic            br_en_i,
    input  logic [2:0]      br_type_i,
    input  logic            jal_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            mem_rd_i,
    input  logic            mem_wr_i,
    input  logic [2:0]      mem_size_i,
    input  logic [4:0]      rd_i,
    input  logic            rd_wr_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            valid_mem_o,
    output logic [XLEN-1:0] pc_mem_o,
    output logic [XLEN-1:0] wb_data_mem_o,
    output logic [XLEN-1:0] store_data_mem_o,
    output logic            mem_rd_mem_o,
    output logic            mem_wr_mem_o,
    output logic [2:0]      mem_size_mem_o,
    output logic [4:0]      rd_mem_o,
    output logic            rd_wr_mem_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            misalign_exc_o
);

    logic            w_taken;
    logic            w_misalign;
    logic [XLEN-1:0] w_target;
    ex_mem_t         w_capture;

    ex_mem_t         r_stage;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_misalign;

    branch_unit #(.XLEN(XLEN)) u_branch_unit (
        .valid_ex_i  (valid_ex_i),
        .res_alu_i   (res_alu_i),
        .z_alu_i     (z_alu_i),
        .n_alu_i     (n_alu_i),
        .br_en_i     (br_en_i),
        .br_type_i   (br_type_i),
        .jal_i       (jal_i),
        .jalr_i      (jalr_i),
        .br_target_i (br_target_i),
        .taken_o     (w_taken),
        .target_o    (w_target),
        .misalign_o  (w_misalign)
    );

    // Value the register would take on a normal (non-stall, non-flush) edge.
    always_comb begin
        w_capture = make_bubble(r_stage);
        if (valid_ex_i) begin
            w_capture.valid      = 1'b1;
            w_capture.pc         = pc_ex_i;
            // Link address wraps naturally in the 32-bit add.
            w_capture.wb_data    = (jal_i | jalr_i) ? (pc_ex_i + 32'd4) : res_alu_i;
            w_capture.store_data = store_data_i;
            // Load+store together is illegal; treat it as a store.
            w_capture.mem_rd     = mem_rd_i & ~mem_wr_i;
            w_capture.mem_wr     = mem_wr_i;
            w_capture.mem_size   = mem_size_i;
            w_capture.rd         = rd_i;
            w_capture.rd_wr      = rd_wr_i;
            // A faulting jump/branch must not leave architectural side effects.
            if (w_misalign) begin
                w_capture.mem_rd = 1'b0;
                w_capture.mem_wr = 1'b0;
                w_capture.rd_wr  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage       <= EX_MEM_BUBBLE;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_misalign    <= 1'b0;
        end else if (flush_i) begin
            r_stage       <= make_bubble(r_stage);
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_misalign    <= 1'b0;
        end else if (stall_i) begin
            // Fields hold; pulses still drop so a redirect is never repeated.
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_stage       <= w_capture;
            r_redirect    <= w_taken & ~w_misalign;
            r_redirect_pc <= w_taken ? w_target : '0;
            r_misalign    <= w_misalign;
        end
    end

    assign valid_mem_o      = r_stage.valid;
    assign pc_mem_o         = r_stage.pc;
    assign wb_data_mem_o    = r_stage.wb_data;
    assign store_data_mem_o = r_stage.store_data;
    assign mem_rd_mem_o     = r_stage.mem_rd;
    assign mem_wr_mem_o     = r_stage.mem_wr;
    assign mem_size_mem_o   = r_stage.mem_size;
    assign rd_mem_o         = r_stage.rd;
    assign rd_wr_mem_o      = r_stage.rd_wr;
    assign redirect_o       = r_redirect;
    assign redirect_pc_o    = r_redirect_pc;
    assign misalign_exc_o   = r_misalign;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        valid_ex_i;
    logic [31:0] pc_ex_i;
    logic [31:0] res_alu_i;
    logic        z_alu_i;
    logic        n_alu_i;
    logic        br_en_i;
    logic [2:0]  br_type_i;
    logic        jal_i;
    logic        jalr_i;
    logic [31:0] br_target_i;
    logic [31:0] store_data_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [2:0]  mem_size_i;
    logic [4:0]  rd_i;
    logic        rd_wr_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_mem_o;
    logic [31:0] pc_mem_o;
    logic [31:0] wb_data_mem_o;
    logic [31:0] store_data_mem_o;
    logic        mem_rd_mem_o;
    logic        mem_wr_mem_o;
    logic [2:0]  mem_size_mem_o;
    logic [4:0]  rd_mem_o;
    logic        rd_wr_mem_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        misalign_exc_o;

    int checks_cnt;
    int fail_cnt;

    ex_mem_stage #(.XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_ex_i       (valid_ex_i),
        .pc_ex_i          (pc_ex_i),
        .res_alu_i        (res_alu_i),
        .z_alu_i          (z_alu_i),
        .n_alu_i          (n_alu_i),
        .br_en_i          (br_en_i),
        .br_type_i        (br_type_i),
        .jal_i            (jal_i),
        .jalr_i           (jalr_i),
        .br_target_i      (br_target_i),
        .store_data_i     (store_data_i),
        .mem_rd_i         (mem_rd_i),
        .mem_wr_i         (mem_wr_i),
        .mem_size_i       (mem_size_i),
        .rd_i             (rd_i),
        .rd_wr_i          (rd_wr_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .valid_mem_o      (valid_mem_o),
        .pc_mem_o         (pc_mem_o),
        .wb_data_mem_o    (wb_data_mem_o),
        .store_data_mem_o (store_data_mem_o),
        .mem_rd_mem_o     (mem_rd_mem_o),
        .mem_wr_mem_o     (mem_wr_mem_o),
        .mem_size_mem_o   (mem_size_mem_o),
        .rd_mem_o         (rd_mem_o),
        .rd_wr_mem_o      (rd_wr_mem_o),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .misalign_exc_o   (misalign_exc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, obs);
        end
    endtask

    task automatic clear_inputs();
        valid_ex_i = 0; pc_ex_i = 0; res_alu_i = 0; z_alu_i = 0; n_alu_i = 0;
        br_en_i = 0; br_type_i = 3'b000; jal_i = 0; jalr_i = 0; br_target_i = 0;
        store_data_i = 0; mem_rd_i = 0; mem_wr_i = 0; mem_size_i = 0;
        rd_i = 0; rd_wr_i = 0; stall_i = 0; flush_i = 0;
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [2:0] t, input logic z, input logic n,
                          input logic [31:0] res, input logic [31:0] pc, input logic [31:0] tgt);
        clear_inputs();
        valid_ex_i = 1; br_en_i = 1; br_type_i = t; z_alu_i = z; n_alu_i = n;
        res_alu_i = res; pc_ex_i = pc; br_target_i = tgt;
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        clear_inputs();
        rst_n = 0;
        #3;
        // Reset state, before any clock edge.
        check("rst_valid",    {31'd0, valid_mem_o}, 32'd0);
        check("rst_pc",       pc_mem_o, 32'd0);
        check("rst_wb",       wb_data_mem_o, 32'd0);
        check("rst_redirect", {31'd0, redirect_o}, 32'd0);
        check("rst_misalign", {31'd0, misalign_exc_o}, 32'd0);
        #4 rst_n = 1;   // released mid-cycle; first capture on next edge

        // BEQ taken
        branch(3'b000, 1'b1, 1'b0, 32'h0, 32'h40, 32'h100);
        tick();
        check("beq_redirect", {31'd0, redirect_o}, 32'd1);
        check("beq_rpc",      redirect_pc_o, 32'h100);
        check("beq_pc_mem",   pc_mem_o, 32'h40);
        check("beq_valid",    {31'd0, valid_mem_o}, 32'd1);
        clear_inputs();
        tick();
        check("beq_pulse_end", {31'd0, redirect_o}, 32'd0);
        check("idle_valid",    {31'd0, valid_mem_o}, 32'd0);

        // Unsigned branches with res=0 (not less-than)
        branch(3'b110, 1'b0, 1'b0, 32'h0, 32'h44, 32'h200);
        tick();
        check("bltu_redirect", {31'd0, redirect_o}, 32'd0);
        branch(3'b111, 1'b0, 1'b0, 32'h0, 32'h48, 32'h200);
        tick();
        check("bgeu_redirect", {31'd0, redirect_o}, 32'd1);
        check("bgeu_rpc",      redirect_pc_o, 32'h200);
        branch(3'b001, 1'b1, 1'b0, 32'h0, 32'h4C, 32'h300);
        tick();
        check("bne_z_redirect", {31'd0, redirect_o}, 32'd0);
        branch(3'b100, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h50, 32'h304);
        tick();
        check("blt_redirect", {31'd0, redirect_o}, 32'd1);
        check("blt_wb",       wb_data_mem_o, 32'hFFFF_FFFF);
        branch(3'b010, 1'b1, 1'b1, 32'h1, 32'h54, 32'h308);
        tick();
        check("br010_redirect", {31'd0, redirect_o}, 32'd0);

        // JALR misaligned
        clear_inputs();
        valid_ex_i = 1; jalr_i = 1; res_alu_i = 32'h203; pc_ex_i = 32'h80; rd_i = 5'd1; rd_wr_i = 1;
        tick();
        check("jalr_mis_exc",   {31'd0, misalign_exc_o}, 32'd1);
        check("jalr_mis_redir", {31'd0, redirect_o}, 32'd0);
        check("jalr_mis_rpc",   redirect_pc_o, 32'h202);
        check("jalr_mis_rdwr",  {31'd0, rd_wr_mem_o}, 32'd0);
        check("jalr_mis_valid", {31'd0, valid_mem_o}, 32'd1);

        // JALR aligned
        res_alu_i = 32'h205;
        tick();
        check("jalr_redir", {31'd0, redirect_o}, 32'd1);
        check("jalr_rpc",   redirect_pc_o, 32'h204);
        check("jalr_wb",    wb_data_mem_o, 32'h84);
        check("jalr_exc",   {31'd0, misalign_exc_o}, 32'd0);
        check("jalr_rdwr",  {31'd0, rd_wr_mem_o}, 32'd1);

        // Load then 3 stall cycles with different EX content
        clear_inputs();
        valid_ex_i = 1; mem_rd_i = 1; rd_i = 5'd5; rd_wr_i = 1; res_alu_i = 32'h1000;
        pc_ex_i = 32'h90; mem_size_i = 3'b010; store_data_i = 32'hAA;
        tick();
        check("ld_rd_mem",  {27'd0, rd_mem_o}, 32'd5);
        check("ld_mem_rd",  {31'd0, mem_rd_mem_o}, 32'd1);
        check("ld_wb",      wb_data_mem_o, 32'h1000);
        check("ld_size",    {29'd0, mem_size_mem_o}, 32'd2);
        clear_inputs();
        valid_ex_i = 1; jal_i = 1; pc_ex_i = 32'hB0; br_target_i = 32'h400; rd_i = 5'd9; rd_wr_i = 1;
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rd",    {27'd0, rd_mem_o}, 32'd5);
            check("stall_wb",    wb_data_mem_o, 32'h1000);
            check("stall_redir", {31'd0, redirect_o}, 32'd0);
        end

        // Redirect pulse followed by stall: exactly one cycle
        stall_i = 0;
        tick();
        check("jal_redir",   {31'd0, redirect_o}, 32'd1);
        check("jal_wb",      wb_data_mem_o, 32'hB4);
        stall_i = 1;
        tick();
        check("jal_stall_redir", {31'd0, redirect_o}, 32'd0);
        check("jal_stall_pc",    pc_mem_o, 32'hB0);
        check("jal_stall_valid", {31'd0, valid_mem_o}, 32'd1);

        // Stall + flush: flush wins, data fields held
        flush_i = 1;
        tick();
        check("sf_valid", {31'd0, valid_mem_o}, 32'd0);
        check("sf_rdwr",  {31'd0, rd_wr_mem_o}, 32'd0);
        check("sf_redir", {31'd0, redirect_o}, 32'd0);
        check("sf_wb",    wb_data_mem_o, 32'hB4);

        // Illegal load+store -> store only
        clear_inputs();
        valid_ex_i = 1; mem_rd_i = 1; mem_wr_i = 1; res_alu_i = 32'h2000; store_data_i = 32'h55;
        tick();
        check("ldst_mem_rd", {31'd0, mem_rd_mem_o}, 32'd0);
        check("ldst_mem_wr", {31'd0, mem_wr_mem_o}, 32'd1);
        check("ldst_sdata",  store_data_mem_o, 32'h55);

        // JAL at top of address space: link wraps
        clear_inputs();
        valid_ex_i = 1; jal_i = 1; pc_ex_i = 32'hFFFF_FFFC; br_target_i = 32'h10; rd_wr_i = 1;
        tick();
        check("wrap_wb",    wb_data_mem_o, 32'h0);
        check("wrap_redir", {31'd0, redirect_o}, 32'd1);

        // Async reset mid-pulse (we are at edge+1; next negedge at edge+5)
        #2 rst_n = 0;
        #1;
        check("arst_redir", {31'd0, redirect_o}, 32'd0);
        check("arst_valid", {31'd0, valid_mem_o}, 32'd0);
        check("arst_pc",    pc_mem_o, 32'd0);
        check("arst_rpc",   redirect_pc_o, 32'd0);
        clear_inputs();
        #4 rst_n = 1;
        pc_ex_i = 32'hC0; valid_ex_i = 1; res_alu_i = 32'h7;
        tick();
        check("post_rst_pc", pc_mem_o, 32'hC0);
        check("post_rst_wb", wb_data_mem_o, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
